pulse_stretcher: RTL and testbench

Converts single-cycle event pulses into level outputs of fixed duration, one independent lane per bit. It is the opposite end of the edge-detector path: the detector turns level transitions into one-cycle pulses, and this block turns one-cycle pulses back into levels. Typical uses are driving LEDs, strobes and external handshake lines from internal event pulses. It sits at the output side of the I/O library, between the pulse-producing logic and the pins.

---
 rtl/pulse_stretcher_pkg.sv | 25 ++
 rtl/pulse_stretcher_lane.sv | 76 +++++++
 rtl/pulse_stretcher.sv | 51 +++++
 tb/tb_pulse_stretcher.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared I/O library constants and helpers
//
// Purpose: polarity constants shared with the edge detector's rise/fall
//          selector, and the counter-width helper used by the stretcher.
// Contents:
//   ACTIVE_HIGH / ACTIVE_LOW : polarity selector values
//   clog2(value)             : ceil(log2(value)), minimum 0

package pulse_stretcher_pkg;

    localparam logic ACTIVE_HIGH = 1'b1;
    localparam logic ACTIVE_LOW  = 1'b0;

    // Elaboration-time helper; returns the number of bits needed to
    // hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_stretcher_lane.sv
// rtl/pulse_stretcher_lane.sv - one lane: pulse to fixed-length level
//
// Purpose: stretches a one-cycle trigger into a level lasting p_LENGTH
//          cycles using a down-counter.
// Configuration macro: PULSE_STRETCHER_RETRIGGER_EN (trigger while busy
//          reloads the counter; otherwise it is dropped and flagged).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pulse        : trigger, sampled every rising edge
//   o_level        : registered stretched level (polarity p_ACTIVE_HIGH)
//   o_overrun      : registered one-cycle dropped-trigger flag
//   o_active       : counter non-zero (feeds the top-level busy OR)

module pulse_stretcher_lane
    import pulse_stretcher_pkg::*;
#(
    parameter int   p_LENGTH      = 4,
    parameter logic p_ACTIVE_HIGH = ACTIVE_HIGH,
    parameter int   p_CNT_W       = clog2(p_LENGTH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    output logic o_level,
    output logic o_overrun,
    output logic o_active
);

    localparam logic [p_CNT_W-1:0] LOAD = p_CNT_W'(p_LENGTH);
    localparam logic [p_CNT_W-1:0] ONE  = p_CNT_W'(1);

    logic [p_CNT_W-1:0] cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               overrun_q, overrun_d;

    always_comb begin
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        // cnt == 1 is the lane's last active cycle, so a trigger there is
        // accepted and the level continues without an idle gap.
        if (i_pulse && (cnt_q <= ONE)) begin
            cnt_d = LOAD;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        else if (i_pulse) begin
            cnt_d = LOAD;
        end
`else
        else if (i_pulse) begin
            cnt_d     = cnt_q - ONE;
            overrun_d = 1'b1;
        end
`endif
        else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
        level_d = (cnt_d != '0) ? p_ACTIVE_HIGH : ~p_ACTIVE_HIGH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            level_q   <= ~p_ACTIVE_HIGH;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_level   = level_q;
    assign o_overrun = overrun_q;
    assign o_active  = (cnt_q != '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - multi-lane pulse-to-level stretcher
//
// Purpose: p_WIDTH independent lanes, each turning a one-cycle trigger
//          into a level lasting p_LENGTH cycles.
// Configuration macro: PULSE_STRETCHER_RETRIGGER_EN (see lane).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   iv_pulse       : per-lane trigger
//   ov_level       : per-lane registered stretched level
//   ov_overrun     : per-lane registered dropped-trigger flag
//   o_busy         : OR of all lanes' active state

module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int   p_WIDTH       = 1,
    parameter int   p_LENGTH      = 4,
    parameter logic p_ACTIVE_HIGH = ACTIVE_HIGH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [p_WIDTH-1:0] iv_pulse,
    output logic [p_WIDTH-1:0] ov_level,
    output logic [p_WIDTH-1:0] ov_overrun,
    output logic               o_busy
);

    localparam int CNT_W = clog2(p_LENGTH + 1);

    logic [p_WIDTH-1:0] lane_active;

    for (genvar g = 0; g < p_WIDTH; g++) begin : g_lane
        pulse_stretcher_lane #(
            .p_LENGTH      (p_LENGTH),
            .p_ACTIVE_HIGH (p_ACTIVE_HIGH),
            .p_CNT_W       (CNT_W)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_pulse   (iv_pulse[g]),
            .o_level   (ov_level[g]),
            .o_overrun (ov_overrun[g]),
            .o_active  (lane_active[g])
        );
    end

    // Each active bit comes straight from a lane's counter register, so
    // busy changes on the same edge as the levels.
    assign o_busy = |lane_active;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - randomized self-checking bench for pulse_stretcher

module tb_pulse_stretcher;
    import pulse_stretcher_pkg::*;

    localparam int   W  = 3;
    localparam int   L  = 4;
    localparam logic AH = ACTIVE_LOW;
    localparam int   NONE = -100000;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [W-1:0] iv_pulse;
    logic [W-1:0] ov_level;
    logic [W-1:0] ov_overrun;
    logic         o_busy;

    logic [0:0]   p1;
    logic [0:0]   l1;
    logic [0:0]   ovr1;
    logic         busy1;

    pulse_stretcher #(.p_WIDTH(W), .p_LENGTH(L), .p_ACTIVE_HIGH(AH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .iv_pulse   (iv_pulse),
        .ov_level   (ov_level),
        .ov_overrun (ov_overrun),
        .o_busy     (o_busy)
    );

    pulse_stretcher #(.p_WIDTH(1), .p_LENGTH(1), .p_ACTIVE_HIGH(ACTIVE_HIGH)) dut1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .iv_pulse   (p1),
        .ov_level   (l1),
        .ov_overrun (ovr1),
        .o_busy     (busy1)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model: edge index of the most recent accepted trigger per
    // lane. A lane is active after edge e iff e < last + length; a new
    // trigger is accepted iff the lane would be idle after this edge
    // anyway (or always, when retriggering).
    int           last_a [W];
    int           last_b;
    logic [W-1:0] exp_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) last_a[i] = NONE;
        last_b  = NONE;
        exp_ovr = '0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_level"},   ov_level,   {W{~AH}});
        check_eq({tag, "_busy"},    o_busy,     1'b0);
        check_eq({tag, "_overrun"}, ov_overrun, '0);
        check_eq({tag, "_level1"},  l1,         1'b0);
    endtask

    task automatic step(input logic [W-1:0] pa, input logic pb);
        logic [W-1:0] exp_lvl;
        logic         any;
        bit           acc;
        iv_pulse = pa;
        p1       = pb;
        @(posedge i_clk);
        edge_n++;
        any = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc        = RETRIG || (edge_n >= last_a[i] + L);
            exp_ovr[i] = pa[i] && !acc;
            if (pa[i] && acc) last_a[i] = edge_n;
            exp_lvl[i] = (edge_n < last_a[i] + L) ? AH : ~AH;
            any        = any | (edge_n < last_a[i] + L);
        end
        if (pb) last_b = edge_n;
        #1;
        check_eq("level",    ov_level,   exp_lvl);
        check_eq("overrun",  ov_overrun, exp_ovr);
        check_eq("busy",     o_busy,     any);
        check_eq("len1_level",   l1,    (edge_n < last_b + 1));
        check_eq("len1_overrun", ovr1,  1'b0);
        check_eq("len1_busy",    busy1, (edge_n < last_b + 1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    initial begin
        iv_pulse = '0;
        p1       = '0;
        i_rst_n  = 1'b1;
        model_reset();
        #1;
        i_rst_n  = 1'b0;
        #1;
        check_idle("reset");
        // Pulses during reset must be ignored.
        iv_pulse = '1;
        p1       = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check_idle("reset_pulse");
        @(negedge i_clk);
        iv_pulse = '0;
        p1       = 1'b0;
        i_rst_n  = 1'b1;

        // Single pulse
        idle(3);
        step(3'b001, 1'b0);
        idle(6);
        // Back-to-back, exactly L apart
        step(3'b001, 1'b0);
        idle(L - 1);
        step(3'b001, 1'b0);
        idle(6);
        // Early retrigger
        step(3'b001, 1'b0);
        idle(1);
        step(3'b001, 1'b0);
        idle(6);
        // Multi-lane
        step(3'b101, 1'b0);
        idle(1);
        step(3'b010, 1'b0);
        idle(6);
        // Length-1 instance with the trigger held for 5 cycles
        for (int k = 0; k < 5; k++) step('0, 1'b1);
        idle(3);

        // Asynchronous reset in the middle of an active window
        step(3'b111, 1'b1);
        step(3'b000, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] pa;
            for (int i = 0; i < W; i++) pa[i] = ($urandom_range(0, 2) == 0);
            step(pa, 1'($urandom_range(0, 1)));
        end
        idle(L + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
